// File: rtl/io_selftest_pkg.sv
// Shared encodings for the pad self-test engine: mode codes, loop FSM states, LFSR constants.
// Pure declarations; no logic, no latency.
package io_selftest_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_COUNT  = 2'd1;
    localparam logic [1:0] MODE_LOOP   = 2'd2;
    localparam logic [1:0] MODE_CLKDIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loop_st_e;

    // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/io_selftest_if.sv
// Control and pad-facing bus of io_selftest; master drives the controls, slave is the engine.
// Plain wiring, no latency and no flow control.
interface io_selftest_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
);
    logic [1:0]       mode;
    logic [2:0]       div_sel;
    logic             start;
    logic [WIDTH-1:0] pass_in;
    logic [WIDTH-1:0] io_in;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] io_out;
    logic [WIDTH-1:0] io_oe;
    logic             busy;
    logic             done;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output mode, div_sel, start, pass_in, io_in,
        input  q_out, io_out, io_oe, busy, done, err_cnt
    );

    modport slave (
        input  mode, div_sel, start, pass_in, io_in,
        output q_out, io_out, io_oe, busy, done, err_cnt
    );
endinterface

// File: rtl/io_selftest_patgen.sv
// Loop-burst pattern source: 16-bit PRBS when IO_SELFTEST_PRBS_EN is defined, else a WIDTH-bit up-counter.
// Pattern is a register: load/adv take effect on the next clock, load has priority.
module io_selftest_patgen
    import io_selftest_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [WIDTH-1:0] pat
);

`ifdef IO_SELFTEST_PRBS_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load)
            lfsr_d = LFSR_SEED;
        else if (adv)
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign pat = lfsr_q[WIDTH-1:0];
`else
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (adv)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pat = cnt_q;
`endif

endmodule

// File: rtl/io_selftest.sv
// Pad self-test engine: PASS / COUNT / LOOP (pattern loopback + error count) / CLKDIV; pattern type via IO_SELFTEST_PRBS_EN.
// Outputs come from registers (1-cycle latency from inputs); LOOP compares io_in against a LAT-deep expected pipeline.
module io_selftest
    import io_selftest_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN   = 256,
    parameter int LAT   = 2,
    parameter int ERR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    io_selftest_if.slave bus
);

    localparam int              CW      = $clog2(LEN + LAT + 1) + 1;
    localparam logic [CW-1:0]   LEN_M1  = CW'(LEN - 1);
    localparam logic [CW-1:0]   LAT_M1  = CW'(LAT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   pass_q, pass_d;
    logic [2*WIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]         div_q, div_d;
    logic               div_clk_q, div_clk_d;
    loop_st_e           st_q, st_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WIDTH-1:0]   exp_q [LAT];
    logic [WIDTH-1:0]   exp_d [LAT];
    logic [LAT-1:0]     vld_q, vld_d;
    logic [WIDTH-1:0]   pat;
    logic               busy, accept, pat_adv;

    assign busy   = (st_q == ST_RUN) || (st_q == ST_DRAIN);
    assign accept = (st_q == ST_IDLE) && bus.start && (bus.mode == MODE_LOOP);
    // Hold the final pattern through DRAIN instead of stepping past it.
    assign pat_adv = (st_q == ST_RUN) && (cyc_q != LEN_M1);

    io_selftest_patgen #(.WIDTH(WIDTH)) u_patgen (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .adv  (pat_adv),
        .pat  (pat)
    );

    always_comb begin
        mode_d    = bus.mode;
        pass_d    = bus.pass_in;
        cnt_d     = (mode_q == MODE_COUNT) ? cnt_q + 1'b1 : cnt_q;
        div_d     = div_q;
        div_clk_d = div_clk_q;
        // Half-period is sampled only at a toggle, so div_sel changes land on the next edge.
        if (mode_q != MODE_CLKDIV) begin
            div_d     = '0;
            div_clk_d = 1'b0;
        end else if (div_q == '0) begin
            div_clk_d = ~div_clk_q;
            div_d     = 7'((8'd1 << bus.div_sel) - 8'd1);
        end else begin
            div_d = div_q - 7'd1;
        end
    end

    always_comb begin
        st_d  = st_q;
        cyc_d = cyc_q;
        err_d = err_q;
        case (st_q)
            ST_IDLE: begin
                if (accept) begin
                    st_d  = ST_RUN;
                    cyc_d = '0;
                    err_d = '0;
                end
            end
            ST_RUN: begin
                if (cyc_q == LEN_M1) begin
                    st_d  = ST_DRAIN;
                    cyc_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cyc_q == LAT_M1)
                    st_d = ST_DONE;
                else
                    cyc_d = cyc_q + 1'b1;
            end
            default: st_d = ST_IDLE;
        endcase
        if (busy && (bus.mode != MODE_LOOP))
            st_d = ST_IDLE;

        // Only entries launched during RUN are compared; the pipe empties whenever no burst is live.
        exp_d[0] = pat;
        vld_d[0] = (st_q == ST_RUN);
        for (int i = 1; i < LAT; i++) begin
            exp_d[i] = exp_q[i-1];
            vld_d[i] = busy && vld_q[i-1];
        end
        if (busy && vld_q[LAT-1] && (bus.io_in != exp_q[LAT-1]) && (err_q != ERR_MAX))
            err_d = err_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_PASS;
            pass_q    <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            div_clk_q <= 1'b0;
            st_q      <= ST_IDLE;
            cyc_q     <= '0;
            err_q     <= '0;
            vld_q     <= '0;
            exp_q     <= '{default: '0};
        end else begin
            mode_q    <= mode_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            div_clk_q <= div_clk_d;
            st_q      <= st_d;
            cyc_q     <= cyc_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            exp_q     <= exp_d;
        end
    end

    always_comb begin
        bus.q_out  = '0;
        bus.io_out = '0;
        bus.io_oe  = '0;
        case (mode_q)
            MODE_PASS: bus.q_out = pass_q;
            MODE_COUNT: begin
                bus.q_out  = cnt_q[WIDTH-1:0];
                bus.io_out = cnt_q[2*WIDTH-1:WIDTH];
                bus.io_oe  = '1;
            end
            MODE_LOOP: begin
                bus.q_out[0] = busy;
                bus.io_out   = pat;
                bus.io_oe    = '1;
            end
            default: begin
                bus.io_out[0] = div_clk_q;
                bus.io_oe[0]  = 1'b1;
            end
        endcase
    end

    assign bus.busy    = busy;
    assign bus.done    = (st_q == ST_DONE);
    assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_io_selftest.sv
// Self-checking bench for io_selftest: vector tables, randomized loopback bursts against a pattern/error model.
`timescale 1ns/1ps
module tb_io_selftest;
    import io_selftest_pkg::*;

    localparam int W     = 8;
    localparam int LEN   = 256;
    localparam int LAT   = 2;
    localparam int ERR_W = 8;
    localparam int NCYC  = LEN + LAT + 4;

    logic clk = 1'b0;
    logic rst;

    io_selftest_if #(.WIDTH(W), .ERR_W(ERR_W)) bus ();

    io_selftest #(.WIDTH(W), .LEN(LEN), .LAT(LAT), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] pats [LEN];

    typedef struct { logic [W-1:0] pin; logic [W-1:0] exp_q; } pass_vec_t;
    typedef struct { logic [2:0] sel; int half; } div_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // kind: 0 clean loopback, 1 bit3 stuck high, 2 all bits inverted, 3/4 random single-bit flips.
    task automatic burst(input string nm, input int kind, input int abort_at, output int model_err);
        logic [W-1:0] outv [0:NCYC];
        logic [W-1:0] inv  [0:NCYC];
        logic [W-1:0] src;
        logic [ERR_W-1:0] err_at_done;
        logic exp_busy, exp_done, live;
        int bad_busy, bad_done, bad_pat, bad_q, nerr;
        bad_busy = 0; bad_done = 0; bad_pat = 0; bad_q = 0; err_at_done = '0;
        @(negedge clk);
        bus.mode = MODE_LOOP; bus.start = 1'b1; bus.io_in = '0;
        outv[0] = bus.io_out; inv[0] = '0;
        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk);
            bus.start = (kind == 3 && c == 50);
            if (abort_at > 0 && c == abort_at) bus.mode = MODE_PASS;
            live     = (abort_at <= 0) || (c <= abort_at);
            exp_busy = (c <= LEN + LAT) && live;
            exp_done = (c == LEN + LAT + 1) && (abort_at <= 0);
            outv[c]  = bus.io_out;
            if (bus.busy !== exp_busy) bad_busy++;
            if (bus.done !== exp_done) bad_done++;
            if (c <= LEN && live && outv[c] !== pats[c-1]) bad_pat++;
            if (live && bus.q_out !== {{(W-1){1'b0}}, exp_busy}) bad_q++;
            if (c == LEN + LAT + 1) err_at_done = bus.err_cnt;
            src = (c >= LAT) ? outv[c-LAT] : '0;
            case (kind)
                0: bus.io_in = src;
                1: bus.io_in = src | W'(8);
                2: bus.io_in = ~src;
                default: bus.io_in = ($urandom_range(0, 7) == 0) ? src ^ (W'(1) << $urandom_range(0, W-1)) : src;
            endcase
            inv[c] = bus.io_in;
        end
        // Pattern k leaves io_out in cycle k+1 and is compared against io_in of cycle k+1+LAT.
        nerr = 0;
        for (int k = 0; k < LEN; k++) begin
            if (abort_at > 0 && k + 1 + LAT > abort_at) break;
            if (inv[k+1+LAT] !== pats[k]) nerr++;
        end
        if (nerr > (1 << ERR_W) - 1) nerr = (1 << ERR_W) - 1;
        model_err = nerr;
        chk({nm, "_busy_cycles_bad"}, bad_busy, 0);
        chk({nm, "_done_cycles_bad"}, bad_done, 0);
        chk({nm, "_pattern_bad"}, bad_pat, 0);
        chk({nm, "_q_out_bad"}, bad_q, 0);
        if (abort_at <= 0) chk({nm, "_err_at_done"}, err_at_done, nerr);
        chk({nm, "_err_final"}, bus.err_cnt, nerr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        pass_vec_t pv [4];
        div_vec_t  dv [4];
        logic [W-1:0] last, v;
        logic [15:0] s;
        logic [2*W-1:0] cur, prev;
        int bad, step_c, held, dummy, tq [$];
        logic [W-1:0] step_v, first_cnt;
        logic lvl;

`ifdef IO_SELFTEST_PRBS_EN
        s = LFSR_SEED;
        for (int k = 0; k < LEN; k++) begin
            pats[k] = s[W-1:0];
            s = (s >> 1) | (16'((s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h1) << 15);
        end
`else
        s = '0;
        for (int k = 0; k < LEN; k++) pats[k] = W'(k);
`endif

        rst = 1'b1; bus.mode = MODE_PASS; bus.div_sel = '0; bus.start = 1'b0;
        bus.pass_in = 8'h5A; bus.io_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_q_out", bus.q_out, 0);
        chk("rst_io", {bus.io_out, bus.io_oe}, 0);
        chk("rst_busy_done_err", {bus.busy, bus.done, bus.err_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("pass_after_rst", bus.q_out, 8'h5A);
        chk("pass_io_oe", {bus.io_out, bus.io_oe}, 0);

        pv = '{'{8'h00, 8'h00}, '{8'hFF, 8'hFF}, '{8'hA5, 8'hA5}, '{8'h3C, 8'h3C}};
        for (int i = 0; i < 4; i++) begin
            bus.pass_in = pv[i].pin;
            @(negedge clk);
            chk("pass_tbl", bus.q_out, pv[i].exp_q);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            v = W'($urandom);
            bus.pass_in = v;
            @(negedge clk);
            if (bus.q_out !== v) bad++;
        end
        chk("pass_rand_bad", bad, 0);

        do_reset();
        bus.mode = MODE_COUNT;
        bad = 0; step_c = -1; step_v = '0; prev = '0; first_cnt = '1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cur = {bus.io_out, bus.q_out};
            if (c == 1) first_cnt = bus.q_out;
            if (c >= 2 && cur !== prev + 1'b1) bad++;
            if (bus.io_oe !== 8'hFF) bad++;
            if (step_c < 0 && bus.io_out !== '0) begin step_c = c; step_v = bus.io_out; end
            prev = cur;
        end
        chk("count_first", first_cnt, 0);
        chk("count_seq_bad", bad, 0);
        chk("count_hi_step_cycle", step_c, 257);
        chk("count_hi_step_val", step_v, 8'h01);

        dv = '{'{3'd2, 4}, '{3'd0, 1}, '{3'd3, 8}, '{3'd1, 2}};
        bus.mode = MODE_CLKDIV;
        for (int i = 0; i < 4; i++) begin
            bus.div_sel = dv[i].sel;
            tq.delete();
            @(negedge clk);
            lvl = bus.io_out[0];
            for (int c = 0; c < 8 * dv[i].half + 20; c++) begin
                @(negedge clk);
                if (bus.io_out[0] !== lvl) begin tq.push_back(c); lvl = bus.io_out[0]; end
            end
            bad = (tq.size() < 4) ? 1 : 0;
            for (int j = 1; j < tq.size(); j++)
                if (tq[j] - tq[j-1] != dv[i].half) bad++;
            chk("clkdiv_half_period_bad", bad, 0);
            chk("clkdiv_oe_io_hi", {bus.io_oe, bus.io_out[W-1:1]}, {8'h01, 7'h00});
        end

        burst("loop_clean", 0, -1, dummy);
        burst("loop_bit3", 1, -1, dummy);
        burst("loop_invert", 2, -1, dummy);
        chk("loop_invert_saturated", bus.err_cnt, 8'hFF);
        burst("loop_rand", 3, -1, dummy);
        burst("loop_abort", 4, 100, held);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy || bus.done) bad++;
        end
        chk("start_in_mode0_ignored", bad, 0);
        chk("err_hold_after_abort", bus.err_cnt, held);

        @(negedge clk);
        bus.mode = MODE_LOOP; bus.start = 1'b1; bus.io_in = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("midburst_err_nonzero", (bus.err_cnt != 0), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_mid_burst", {bus.busy, bus.done, bus.err_cnt, bus.io_oe, bus.io_out, bus.q_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done) bad++;
        end
        chk("idle_after_rst", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
